// File: rtl/freq_bcd_converter.sv
// ---------------------------------------------------------------------------
// freq_bcd_converter
//
// Sits after the edge counter of the frequency counter. When the gate window
// (enable) closes, the latched count (cnt_mem) is captured and converted to
// packed BCD with a shift-and-add-3 (double-dabble) engine, one bit per clock.
// The result is shown with a leading-zero mask and a one-cycle valid strobe.
//
// Ports:
//   clk          system clock, rising edge
//   async_rst_n  asynchronous active-low reset
//   enable       gate window, high while counting
//   cnt_mem      latched count, sampled once per conversion in LOAD
//   bcd_out      packed BCD result, digit 0 in bits [3:0], held until next result
//   digit_en     leading-zero mask, bit 0 always set
//   bcd_valid    one-cycle strobe in the cycle bcd_out/digit_en update
//   busy         conversion in progress (LOAD, SHIFT, DONE)
//   overrun      one-cycle pulse when a gate falling edge arrives while busy
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module freq_bcd_converter #(
    parameter int CNT_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      cnt_mem,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic                  overrun
);

    // The digit count must be able to hold the largest possible count.
    function automatic bit digits_cover(input int cw, input int dg);
        logic [127:0] p10;
        p10 = 128'd1;
        for (int i = 0; i < dg; i++) begin
            p10 = p10 * 128'd10;
        end
        return p10 > (128'd1 << cw);
    endfunction

    localparam bit DIGITS_OK = digits_cover(CNT_W, DIGITS);

    generate
        if (!DIGITS_OK) begin : g_bad_digits
            $fatal(1, "freq_bcd_converter: DIGITS too small for CNT_W");
        end
    endgenerate

    localparam int ACC_W = 4 * DIGITS;
    localparam int BC_W  = $clog2(CNT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q,     state_d;
    logic               en_dly_q,    en_dly_d;
    logic [CNT_W-1:0]   sr_q,        sr_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic [BC_W-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [ACC_W-1:0]   bcd_q,       bcd_d;
    logic [DIGITS-1:0]  digit_en_q,  digit_en_d;
    logic               valid_q,     valid_d;
    logic               busy_q,      busy_d;
    logic               overrun_q,   overrun_d;

    logic               fall;
    logic [ACC_W-1:0]   acc_adj;
    logic [DIGITS-1:0]  digit_nz;
    logic [DIGITS-1:0]  acc_mask;

    assign fall = en_dly_q & ~enable;

    // Per-digit add-3 correction ahead of each shift; no inter-digit carry is
    // possible because every digit stays <= 9 between iterations.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5)
                                      ? acc_q[4*gi +: 4] + 4'd3
                                      : acc_q[4*gi +: 4];
            assign digit_nz[gi] = |acc_q[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign acc_mask[gi] = 1'b1;
            end else begin : g_upper
                assign acc_mask[gi] = |digit_nz[DIGITS-1:gi];
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        en_dly_d   = enable;
        sr_d       = sr_q;
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        bcd_d      = bcd_q;
        digit_en_d = digit_en_q;
        valid_d    = 1'b0;
        overrun_d  = fall & (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sr_d      = cnt_mem;
                acc_d     = '0;
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                {acc_d, sr_d} = {acc_adj, sr_q} << 1;
                bit_cnt_d     = bit_cnt_q + BC_W'(1);
                if (bit_cnt_q == BC_W'(CNT_W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d      = acc_q;
                digit_en_d = acc_mask;
                valid_d    = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q    <= S_IDLE;
            en_dly_q   <= 1'b0;
            sr_q       <= '0;
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            bcd_q      <= '0;
            digit_en_q <= DIGITS'(1);
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_dly_q   <= en_dly_d;
            sr_q       <= sr_d;
            acc_q      <= acc_d;
            bit_cnt_q  <= bit_cnt_d;
            bcd_q      <= bcd_d;
            digit_en_q <= digit_en_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign digit_en  = digit_en_q;
    assign bcd_valid = valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_freq_bcd_converter.sv
`timescale 1ns/1ps

module tb_freq_bcd_converter;

    localparam int CNT_W  = 16;
    localparam int DIGITS = 5;

    logic                 clk = 1'b0;
    logic                 async_rst_n;
    logic                 enable;
    logic [CNT_W-1:0]     cnt_mem;
    logic [4*DIGITS-1:0]  bcd_out;
    logic [DIGITS-1:0]    digit_en;
    logic                 bcd_valid;
    logic                 busy;
    logic                 overrun;

    int errors = 0;
    int checks = 0;

    // Running counts of output activity, sampled on the falling edge.
    int valid_cnt   = 0;
    int overrun_cnt = 0;
    int busy_cnt    = 0;

    typedef struct {
        int                  v;
        logic [4*DIGITS-1:0] bcd;
        logic [DIGITS-1:0]   en;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    freq_bcd_converter #(.CNT_W(CNT_W), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .enable      (enable),
        .cnt_mem     (cnt_mem),
        .bcd_out     (bcd_out),
        .digit_en    (digit_en),
        .bcd_valid   (bcd_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always @(negedge clk) begin
        if (bcd_valid) valid_cnt++;
        if (overrun)   overrun_cnt++;
        if (busy)      busy_cnt++;
    end

    // Reference: decimal digits by repeated division.
    function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference mask: digit i is shown iff the value reaches 10^i.
    function automatic logic [DIGITS-1:0] ref_en(input int v);
        logic [DIGITS-1:0] r;
        int p;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[i] = (i == 0) || (v >= p);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic exp_t make_exp(input int v);
        exp_t e;
        e.v   = v;
        e.bcd = ref_bcd(v);
        e.en  = ref_en(v);
        return e;
    endfunction

    // One gate window for value v; result popped from the scoreboard on bcd_valid.
    task automatic run_conv(input int v, input bit chk_timing);
        exp_t e;
        int   lat;
        int   busy_n;
        sb_q.push_back(make_exp(v));
        @(posedge clk); #1 cnt_mem = CNT_W'(v); enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk);                         // fall sampled here (E0)
        @(negedge clk);
        busy_n = busy ? 1 : 0;
        lat    = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bcd_valid) begin
                lat = n;
                break;
            end
            if (busy) busy_n++;
        end
        e = sb_q.pop_front();
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL conv_timeout v=%0d: no bcd_valid within 40 clk", e.v);
            return;
        end
        checks++;
        if (bcd_out !== e.bcd) begin
            errors++;
            $display("FAIL bcd_out v=%0d: got %h expected %h", e.v, bcd_out, e.bcd);
        end
        if (digit_en !== e.en) begin
            errors++;
            $display("FAIL digit_en v=%0d: got %b expected %b", e.v, digit_en, e.en);
        end
        if (chk_timing) begin
            checks += 3;
            if (lat != 18) begin
                errors++;
                $display("FAIL latency v=%0d: got %0d expected 18", e.v, lat);
            end
            if (busy_n != 18) begin
                errors++;
                $display("FAIL busy_cycles v=%0d: got %0d expected 18", e.v, busy_n);
            end
            @(negedge clk);
            if (bcd_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_width v=%0d: got %b expected 0", e.v, bcd_valid);
            end
        end
        $display("conv v=%0d bcd=%h en=%b lat=%0d", e.v, bcd_out, digit_en, lat);
    endtask

    task automatic test_reset();
        async_rst_n = 1'b0;
        enable      = 1'b0;
        cnt_mem     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (bcd_out !== '0)          begin errors++; $display("FAIL reset_bcd: got %h expected 0", bcd_out); end
        if (digit_en !== 5'b00001)   begin errors++; $display("FAIL reset_en: got %b expected 00001", digit_en); end
        if (bcd_valid !== 1'b0)      begin errors++; $display("FAIL reset_valid: got %b expected 0", bcd_valid); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (overrun !== 1'b0)        begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        @(posedge clk); #1 async_rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_values();
        run_conv(12345, 1'b1);
        run_conv(0, 1'b1);
        run_conv(407, 1'b1);
        run_conv(65535, 1'b1);
    endtask

    // Second fall 5 clk after the first, cnt_mem changed: must be ignored.
    task automatic test_overrun();
        int v0, o0, lat, ov5;
        logic [4*DIGITS-1:0] cap_bcd;
        logic [DIGITS-1:0]   cap_en;
        exp_t e;
        v0 = valid_cnt; o0 = overrun_cnt; lat = 0; ov5 = 0;
        cap_bcd = '0; cap_en = '0;
        sb_q.push_back(make_exp(12345));
        @(posedge clk); #1 cnt_mem = 16'd12345; enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk);                         // E0
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk); #1;
            if (n == 3) begin enable = 1'b1; cnt_mem = 16'd999; end
            if (n == 4) enable = 1'b0;
            @(negedge clk);
            if (n == 5) ov5 = overrun ? 1 : 0;
            if (bcd_valid && lat == 0) begin
                lat = n; cap_bcd = bcd_out; cap_en = digit_en;
            end
        end
        @(posedge clk);
        e = sb_q.pop_front();
        checks += 6;
        if (ov5 != 1)                   begin errors++; $display("FAIL overrun_pulse: got %0d expected 1", ov5); end
        if (overrun_cnt - o0 != 1)      begin errors++; $display("FAIL overrun_count: got %0d expected 1", overrun_cnt - o0); end
        if (lat != 18)                  begin errors++; $display("FAIL overrun_latency: got %0d expected 18", lat); end
        if (valid_cnt - v0 != 1)        begin errors++; $display("FAIL overrun_valids: got %0d expected 1", valid_cnt - v0); end
        if (cap_bcd !== e.bcd)          begin errors++; $display("FAIL overrun_bcd: got %h expected %h", cap_bcd, e.bcd); end
        if (cap_en !== e.en)            begin errors++; $display("FAIL overrun_en: got %b expected %b", cap_en, e.en); end
        $display("overrun test: pulses=%0d valids=%0d bcd=%h", overrun_cnt - o0, valid_cnt - v0, cap_bcd);
    endtask

    // Second fall exactly CNT_W+3 clocks after the first must be accepted.
    task automatic test_back_to_back();
        int o0, l1, l2;
        logic [4*DIGITS-1:0] b1, b2;
        exp_t e1, e2;
        o0 = overrun_cnt; l1 = 0; l2 = 0; b1 = '0; b2 = '0;
        sb_q.push_back(make_exp(111));
        sb_q.push_back(make_exp(222));
        @(posedge clk); #1 cnt_mem = 16'd111; enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk);                         // E0
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk); #1;
            if (n == 17) enable = 1'b1;
            if (n == 18) begin enable = 1'b0; cnt_mem = 16'd222; end
            @(negedge clk);
            if (bcd_valid) begin
                if (l1 == 0) begin l1 = n; b1 = bcd_out; end
                else if (l2 == 0) begin l2 = n; b2 = bcd_out; end
            end
        end
        @(posedge clk);
        e1 = sb_q.pop_front();
        e2 = sb_q.pop_front();
        checks += 5;
        if (l1 != 18)               begin errors++; $display("FAIL b2b_lat1: got %0d expected 18", l1); end
        if (l2 != 37)               begin errors++; $display("FAIL b2b_lat2: got %0d expected 37", l2); end
        if (b1 !== e1.bcd)          begin errors++; $display("FAIL b2b_bcd1: got %h expected %h", b1, e1.bcd); end
        if (b2 !== e2.bcd)          begin errors++; $display("FAIL b2b_bcd2: got %h expected %h", b2, e2.bcd); end
        if (overrun_cnt != o0)      begin errors++; $display("FAIL b2b_overrun: got %0d expected 0", overrun_cnt - o0); end
        $display("back-to-back: lat1=%0d lat2=%0d bcd1=%h bcd2=%h", l1, l2, b1, b2);
    endtask

    // Reset asserted mid-SHIFT clears outputs at once and suppresses the result.
    task automatic test_reset_mid();
        int v0;
        @(posedge clk); #1 cnt_mem = 16'd5555; enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk);                         // E0
        repeat (8) @(posedge clk);
        #1 async_rst_n = 1'b0;
        #1;
        v0 = valid_cnt;
        checks += 4;
        if (bcd_out !== '0)        begin errors++; $display("FAIL midrst_bcd: got %h expected 0", bcd_out); end
        if (digit_en !== 5'b00001) begin errors++; $display("FAIL midrst_en: got %b expected 00001", digit_en); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (bcd_valid !== 1'b0)    begin errors++; $display("FAIL midrst_valid: got %b expected 0", bcd_valid); end
        repeat (3) @(posedge clk);
        #1 async_rst_n = 1'b1;
        repeat (30) @(posedge clk);
        checks++;
        if (valid_cnt != v0) begin errors++; $display("FAIL midrst_novalid: got %0d expected 0", valid_cnt - v0); end
        $display("mid-conversion reset: valids after reset=%0d", valid_cnt - v0);
        run_conv(2024, 1'b1);
    endtask

    // Enable stuck low, then stuck high: no conversion, outputs hold.
    task automatic test_stuck();
        int v0, b0, o0;
        @(posedge clk); #1 async_rst_n = 1'b0; enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 async_rst_n = 1'b1;
        v0 = valid_cnt; b0 = busy_cnt; o0 = overrun_cnt;
        repeat (100) @(posedge clk);
        #1 enable = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (valid_cnt != v0)   begin errors++; $display("FAIL stuck_valid: got %0d expected 0", valid_cnt - v0); end
        if (busy_cnt != b0)    begin errors++; $display("FAIL stuck_busy: got %0d expected 0", busy_cnt - b0); end
        if (overrun_cnt != o0) begin errors++; $display("FAIL stuck_overrun: got %0d expected 0", overrun_cnt - o0); end
        if (bcd_out !== '0)    begin errors++; $display("FAIL stuck_hold: got %h expected 0", bcd_out); end
        $display("stuck enable: valids=%0d busy_cycles=%0d", valid_cnt - v0, busy_cnt - b0);
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 1000; v++) run_conv(v, 1'b0);
        for (int k = 1; k <= CNT_W; k++) begin
            run_conv((1 << k) - 1, 1'b0);
            if (k < CNT_W) run_conv(1 << k, 1'b0);
        end
        run_conv(9999, 1'b0);
        run_conv(10000, 1'b0);
        run_conv(59999, 1'b0);
        run_conv(60000, 1'b0);
        for (int i = 0; i < 400; i++) run_conv(int'($urandom_range(0, 65535)), 1'b0);
    endtask

    initial begin
        test_reset();
        test_values();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_stuck();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
